// File: rtl/multiport_frame_arbiter.sv
// Arbitrates NUM_PORTS frame-buffer requesters onto NUM_BANKS SRAM banks through a rotating role->buffer map.
// Latency: grant and bank drive are combinational; read data returns READ_LATENCY cycles after the grant.
// Backpressure: a losing port sees gnt=0 and holds its request; the read return path is never stalled.
module multiport_frame_arbiter #(
    parameter int NUM_PORTS    = 4,
    parameter int NUM_BANKS    = 2,
    parameter int DATA_W       = 36,
    parameter int ADDR_W       = 19,
    parameter int OFFSET_W     = 17,
    parameter int IMAGE_LENGTH = 76800,
    parameter int READ_LATENCY = 3,
    parameter int ARB_MODE     = 0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          frame_flag,
    input  logic [NUM_PORTS-1:0]          req,
    input  logic [NUM_PORTS-1:0]          wr,
    input  logic [NUM_PORTS*OFFSET_W-1:0] offset,
    input  logic [NUM_PORTS*DATA_W-1:0]   wdata,
    output logic [NUM_PORTS-1:0]          gnt,
    output logic [NUM_PORTS-1:0]          rvalid,
    output logic [NUM_PORTS*DATA_W-1:0]   rdata,
    output logic [NUM_BANKS*ADDR_W-1:0]   mem_addr,
    output logic [NUM_BANKS*DATA_W-1:0]   mem_wdata,
    output logic [NUM_BANKS-1:0]          mem_we,
    input  logic [NUM_BANKS*DATA_W-1:0]   mem_rdata
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [PW-1:0]     buf_of_role [NUM_PORTS];
    logic [PW-1:0]     rr_ptr      [NUM_BANKS];
    logic              pipe_vld    [NUM_BANKS][READ_LATENCY];
    logic [PW-1:0]     pipe_port   [NUM_BANKS][READ_LATENCY];
    logic [ADDR_W-1:0] port_addr   [NUM_PORTS];
    logic              bank_hit    [NUM_BANKS];
    logic [PW-1:0]     bank_win    [NUM_BANKS];

    // Buffer b lives in bank b % NUM_BANKS at image slot b / NUM_BANKS.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            port_addr[p] = ADDR_W'((int'(buf_of_role[p]) / NUM_BANKS) * IMAGE_LENGTH
                                   + int'(offset[p*OFFSET_W +: OFFSET_W]));
        end
    end

    always_comb begin : arb
        int cp;
        cp        = 0;
        gnt       = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            bank_hit[k] = 1'b0;
            bank_win[k] = '0;
            // Scan order starts at the rr pointer in round-robin mode, at port 0 otherwise.
            for (int i = 0; i < NUM_PORTS; i++) begin
                cp = (ARB_MODE == 1) ? (int'(rr_ptr[k]) + i) % NUM_PORTS : i;
                if (!bank_hit[k] && req[cp] && (int'(buf_of_role[cp]) % NUM_BANKS == k)) begin
                    bank_hit[k] = 1'b1;
                    bank_win[k] = PW'(cp);
                end
            end
            if (reset && bank_hit[k]) begin
                gnt[bank_win[k]]                = 1'b1;
                mem_addr[k*ADDR_W +: ADDR_W]    = port_addr[bank_win[k]];
                mem_wdata[k*DATA_W +: DATA_W]   = wdata[int'(bank_win[k])*DATA_W +: DATA_W];
                mem_we[k]                       = wr[bank_win[k]];
            end
        end
    end

    // At most one bank can return to a given port, since a port maps to exactly one bank.
    always_comb begin
        rvalid = '0;
        rdata  = '0;
        if (reset) begin
            for (int k = 0; k < NUM_BANKS; k++) begin
                if (pipe_vld[k][READ_LATENCY-1]) begin
                    rvalid[pipe_port[k][READ_LATENCY-1]] = 1'b1;
                    rdata[int'(pipe_port[k][READ_LATENCY-1])*DATA_W +: DATA_W] =
                        mem_rdata[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                buf_of_role[p] <= PW'(p);
            end
            for (int k = 0; k < NUM_BANKS; k++) begin
                rr_ptr[k] <= '0;
                for (int s = 0; s < READ_LATENCY; s++) begin
                    pipe_vld[k][s]  <= 1'b0;
                    pipe_port[k][s] <= '0;
                end
            end
        end else begin
            if (frame_flag) begin
                for (int p = 0; p < NUM_PORTS; p++) begin
                    buf_of_role[p] <= buf_of_role[(p + NUM_PORTS - 1) % NUM_PORTS];
                end
            end
            for (int k = 0; k < NUM_BANKS; k++) begin
                if (ARB_MODE == 1 && bank_hit[k]) begin
                    rr_ptr[k] <= PW'((int'(bank_win[k]) + 1) % NUM_PORTS);
                end
                pipe_vld[k][0]  <= bank_hit[k] && !wr[bank_win[k]];
                pipe_port[k][0] <= bank_win[k];
                for (int s = 1; s < READ_LATENCY; s++) begin
                    pipe_vld[k][s]  <= pipe_vld[k][s-1];
                    pipe_port[k][s] <= pipe_port[k][s-1];
                end
            end
        end
    end

endmodule
